// File: rtl/corner_pkg.sv
// Shared types and default geometry for the corner extractor.
//   state_e      : scan controller states
//   corner_sel_e : which card corner is extracted
//   Default*     : default frame and corner window geometry
package corner_pkg;

  localparam int unsigned DefaultWidth   = 240;
  localparam int unsigned DefaultHeight  = 320;
  localparam int unsigned DefaultCornerW = 40;
  localparam int unsigned DefaultCornerH = 60;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDrain = 2'd2
  } state_e;

  typedef enum logic {
    SelTopLeft  = 1'b0,
    SelBotRight = 1'b1
  } corner_sel_e;

  // Clamp a window span to the nominal corner size.
  function automatic int unsigned clamp_span(int unsigned span, int unsigned limit);
    return (span < limit) ? span : limit;
  endfunction

endpackage

// File: rtl/corner_addr_gen.sv
// Window address generator for the corner extractor.
// Walks a win_w_i x win_h_i window in raster order starting at the selected corner.
// The row base is advanced by +/-WIDTH per row, so the per-pixel path is add-only;
// the single multiply happens once at load.
// Ports:
//   clk_in, rst_in      : clock, synchronous active-high reset
//   load_i              : latch start corner and compute first address
//   step_i              : advance to next address (ignored on the final address)
//   sel_i               : 0 = top-left walk, 1 = bottom-right walk (reversed)
//   left_i..bot_i       : card box edges, inclusive
//   win_w_i, win_h_i    : window size, stable while stepping
//   addr_o              : current address, held when not stepping
//   last_o              : current address is the final one of the window
// Build option: CORNER_ROTATE_EN enables the decrementing (bottom-right) walk.
module corner_addr_gen
  import corner_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned HEIGHT = DefaultHeight,
  parameter int unsigned XW     = $clog2(WIDTH),
  parameter int unsigned YW     = $clog2(HEIGHT),
  parameter int unsigned AW     = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          sel_i,
  input  logic [XW-1:0] left_i,
  input  logic [XW-1:0] right_i,
  input  logic [YW-1:0] top_i,
  input  logic [YW-1:0] bot_i,
  input  logic [XW-1:0] win_w_i,
  input  logic [YW-1:0] win_h_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  localparam logic [AW-1:0] RowStep = AW'(WIDTH);

  logic [XW-1:0] x_cnt_q;
  logic [YW-1:0] y_cnt_q;
  logic [AW-1:0] addr_q, row_base_q, x_start_q;
  logic [AW-1:0] first_row, first_x, next_row_base, next_addr;
  logic          row_end;

`ifdef CORNER_ROTATE_EN
  logic dir_q;

  assign first_row     = sel_i ? AW'(bot_i) : AW'(top_i);
  assign first_x       = sel_i ? AW'(right_i) : AW'(left_i);
  assign next_row_base = dir_q ? (row_base_q - RowStep) : (row_base_q + RowStep);
  assign next_addr     = dir_q ? (addr_q - AW'(1)) : (addr_q + AW'(1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dir_q <= 1'b0;
    end else if (load_i) begin
      dir_q <= sel_i;
    end
  end
`else
  logic unused_rotate;

  assign unused_rotate = ^{sel_i, right_i, bot_i};
  assign first_row     = AW'(top_i);
  assign first_x       = AW'(left_i);
  assign next_row_base = row_base_q + RowStep;
  assign next_addr     = addr_q + AW'(1);
`endif

  assign row_end = (x_cnt_q == (win_w_i - XW'(1)));
  assign last_o  = row_end && (y_cnt_q == (win_h_i - YW'(1)));
  assign addr_o  = addr_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      addr_q     <= '0;
      row_base_q <= '0;
      x_start_q  <= '0;
    end else if (load_i) begin
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      row_base_q <= first_row * RowStep;
      addr_q     <= (first_row * RowStep) + first_x;
      x_start_q  <= first_x;
    end else if (step_i && !last_o) begin
      // Never step past the final address so addr_o holds it after the scan.
      if (row_end) begin
        x_cnt_q    <= '0;
        y_cnt_q    <= y_cnt_q + YW'(1);
        row_base_q <= next_row_base;
        addr_q     <= next_row_base + x_start_q;
      end else begin
        x_cnt_q <= x_cnt_q + XW'(1);
        addr_q  <= next_addr;
      end
    end
  end

endmodule

// File: rtl/corner_extractor.sv
// Corner extractor: reads a corner window of a card box out of a frame BRAM and
// streams it as contiguous valid beats, one pixel per cycle.
// Ports:
//   clk_in, rst_in                 : clock, synchronous active-high reset
//   start_flag                     : single-cycle request, honoured only when idle
//   left/right/top/bot_edge        : card box, inclusive
//   corner_sel                     : 0 = top-left, 1 = bottom-right rotated 180 degrees
//   pixel_data_in / addr_out       : frame BRAM read port (READ_LATENCY cycles)
//   pixel_out, pixel_valid_out,
//   pixel_last_out                 : extracted pixel stream
//   corner_width, corner_height    : latched window size
//   busy_out, done_out, error_out  : status; done/error are one-cycle pulses
// Build option: CORNER_ROTATE_EN enables corner_sel; without it the scan is always top-left.
module corner_extractor
  import corner_pkg::*;
#(
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned HEIGHT       = DefaultHeight,
  parameter int unsigned PIXEL_W      = 16,
  parameter int unsigned CORNER_W     = DefaultCornerW,
  parameter int unsigned CORNER_H     = DefaultCornerH,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned XW = $clog2(WIDTH),
  localparam int unsigned YW = $clog2(HEIGHT),
  localparam int unsigned AW = $clog2(WIDTH * HEIGHT)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_flag,
  input  logic [XW-1:0]      left_edge,
  input  logic [XW-1:0]      right_edge,
  input  logic [YW-1:0]      top_edge,
  input  logic [YW-1:0]      bot_edge,
  input  logic               corner_sel,
  input  logic [PIXEL_W-1:0] pixel_data_in,
  output logic [AW-1:0]      addr_out,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_valid_out,
  output logic               pixel_last_out,
  output logic [XW-1:0]      corner_width,
  output logic [YW-1:0]      corner_height,
  output logic               busy_out,
  output logic               done_out,
  output logic               error_out
);

  state_e state_q, state_d;

  logic [XW-1:0]      corner_width_q;
  logic [YW-1:0]      corner_height_q;
  logic [XW-1:0]      win_w_d;
  logic [YW-1:0]      win_h_d;
  corner_sel_e        sel_q, sel_d;
  logic               error_q, done_q;
  logic               box_bad, accept, load, issue, win_last;
  logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d, pipe_last_q, pipe_last_d;
  logic [PIXEL_W-1:0] pixel_q;
  logic               pixel_valid_q, pixel_last_q;

  assign box_bad = (right_edge < left_edge) || (bot_edge < top_edge) ||
                   (32'(right_edge) >= WIDTH) || (32'(bot_edge) >= HEIGHT);

  assign win_w_d = XW'(clamp_span(32'(right_edge) - 32'(left_edge) + 32'd1, CORNER_W));
  assign win_h_d = YW'(clamp_span(32'(bot_edge) - 32'(top_edge) + 32'd1, CORNER_H));

`ifdef CORNER_ROTATE_EN
  assign sel_d = corner_sel_e'(corner_sel);
`else
  logic unused_corner_sel;
  assign unused_corner_sel = corner_sel;
  assign sel_d             = SelTopLeft;
`endif

  assign accept = (state_q == StIdle) && start_flag;
  assign load   = accept && !box_bad;
  assign issue  = (state_q == StIssue);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load) state_d = StIssue;
      StIssue: if (win_last) state_d = StDrain;
      StDrain: if (pixel_last_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= StIdle;
      corner_width_q  <= '0;
      corner_height_q <= '0;
      sel_q           <= SelTopLeft;
      error_q         <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= accept && box_bad;
      done_q  <= (state_q == StDrain) && pixel_last_q;
      if (load) begin
        corner_width_q  <= win_w_d;
        corner_height_q <= win_h_d;
        sel_q           <= sel_d;
      end
    end
  end

  corner_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .XW     (XW),
    .YW     (YW),
    .AW     (AW)
  ) u_addr_gen (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load_i  (load),
    .step_i  (issue),
    .sel_i   (sel_d),
    .left_i  (left_edge),
    .right_i (right_edge),
    .top_i   (top_edge),
    .bot_i   (bot_edge),
    .win_w_i (corner_width_q),
    .win_h_i (corner_height_q),
    .addr_o  (addr_out),
    .last_o  (win_last)
  );

  // Valid/last ride alongside the BRAM read so they line up with pixel_data_in.
  if (READ_LATENCY > 1) begin : g_pipe_multi
    assign pipe_valid_d = {pipe_valid_q[READ_LATENCY-2:0], issue};
    assign pipe_last_d  = {pipe_last_q[READ_LATENCY-2:0], issue && win_last};
  end else begin : g_pipe_single
    assign pipe_valid_d = issue;
    assign pipe_last_d  = issue && win_last;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pipe_valid_q  <= '0;
      pipe_last_q   <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      pixel_last_q  <= 1'b0;
    end else begin
      pipe_valid_q  <= pipe_valid_d;
      pipe_last_q   <= pipe_last_d;
      pixel_valid_q <= pipe_valid_q[READ_LATENCY-1];
      pixel_last_q  <= pipe_last_q[READ_LATENCY-1];
      if (pipe_valid_q[READ_LATENCY-1]) begin
        pixel_q <= pixel_data_in;
      end
    end
  end

  logic unused_sel_q;
  assign unused_sel_q = sel_q;

  assign pixel_out       = pixel_q;
  assign pixel_valid_out = pixel_valid_q;
  assign pixel_last_out  = pixel_last_q;
  assign corner_width    = corner_width_q;
  assign corner_height   = corner_height_q;
  assign busy_out        = (state_q != StIdle) || done_q;
  assign done_out        = done_q;
  assign error_out       = error_q;

endmodule
